wb_master_bridge: RTL and testbench

Registered, parametrised Wishbone classic master sitting between the CPU load/store port and the system Wishbone bus. It latches a single-cycle request, runs one classic bus cycle with registered CYC/STB, and returns read data with a one-cycle acknowledge. Unlike a combinational pass-through, it adds error termination, an optional bus timeout, a busy indication, and configurable data/address widths.

---
 rtl/wb_master_bridge_if.sv | 41 ++++
 rtl/wb_master_bridge.sv | 114 +++++++++++
 tb/tb_wb_master_bridge.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/wb_master_bridge_if.sv
// Bundle of the CPU load/store request port and the Wishbone master port of wb_master_bridge.
// The master modport is the bridge side. The slave modport is the CPU/bus environment side.
interface wb_master_bridge_if #(
  parameter int DW = 32,
  parameter int AW = 30
);
  localparam int SW = DW / 8;
  localparam int BW = $clog2(SW);

  logic          i_we;
  logic          i_re;
  logic [SW-1:0] i_sel;
  logic [AW-1:0] i_adr;
  logic [DW-1:0] i_din;
  logic [DW-1:0] o_dout;
  logic          o_ack;
  logic          o_err;
  logic          o_busy;

  logic             o_wb_cyc;
  logic             o_wb_stb;
  logic             o_wb_we;
  logic [SW-1:0]    o_wb_sel;
  logic [AW+BW-1:0] o_wb_adr;
  logic [DW-1:0]    o_wb_dat;
  logic [DW-1:0]    i_wb_dat;
  logic             i_wb_ack;
  logic             i_wb_err;

  modport master (
    input  i_we, i_re, i_sel, i_adr, i_din, i_wb_dat, i_wb_ack, i_wb_err,
    output o_dout, o_ack, o_err, o_busy,
           o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_adr, o_wb_dat
  );

  modport slave (
    output i_we, i_re, i_sel, i_adr, i_din, i_wb_dat, i_wb_ack, i_wb_err,
    input  o_dout, o_ack, o_err, o_busy,
           o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_adr, o_wb_dat
  );
endinterface

// File: rtl/wb_master_bridge.sv
// Registered Wishbone classic master: one request at a time, error/ack termination, busy flag.
// Optional bus timeout is compiled in with `define WB_BRIDGE_TIMEOUT_EN.
module wb_master_bridge #(
  parameter int DW      = 32,
  parameter int AW      = 30,
  parameter int TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_arst_n,
  wb_master_bridge_if.master bus
);
  localparam int SW = DW / 8;
  localparam int BW = $clog2(SW);

  typedef enum logic {IDLE, BUS} state_t;
  state_t state, state_d;

  logic          cyc_q, stb_q, we_q, ack_q, err_q, busy_q;
  logic [SW-1:0] sel_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] dat_q, dout_q;
  logic          req, done_ack, done_err, tmo;

  assign req = bus.i_we | bus.i_re;

`ifdef WB_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;

  // Counts only while staying in BUS, so entry and any termination both leave it cleared.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n)                         tmo_cnt <= '0;
    else if (state == BUS && state_d == BUS) tmo_cnt <= tmo_cnt + 1'b1;
    else                                   tmo_cnt <= '0;
  end

  assign tmo = (tmo_cnt == CW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign tmo = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) state <= IDLE;
    else           state <= state_d;
  end

  always_comb begin
    state_d  = state;
    done_ack = 1'b0;
    done_err = 1'b0;
    case (state)
      IDLE: if (req) state_d = BUS;
      BUS: begin
        if (bus.i_wb_err) begin
          done_err = 1'b1;
          state_d  = IDLE;
        end else if (bus.i_wb_ack) begin
          done_ack = 1'b1;
          state_d  = IDLE;
        end else if (tmo) begin
          done_err = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      cyc_q  <= 1'b0;
      stb_q  <= 1'b0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      adr_q  <= '0;
      dat_q  <= '0;
      dout_q <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      ack_q  <= done_ack;
      err_q  <= done_err;
      busy_q <= (state_d == BUS);
      // Write wins when both strobes arrive together.
      if (state == IDLE && req) begin
        we_q  <= bus.i_we;
        sel_q <= bus.i_sel;
        adr_q <= bus.i_adr;
        dat_q <= bus.i_din;
        cyc_q <= 1'b1;
        stb_q <= 1'b1;
      end
      if (done_ack || done_err) begin
        cyc_q <= 1'b0;
        stb_q <= 1'b0;
      end
      if (done_ack && !we_q) dout_q <= bus.i_wb_dat;
    end
  end

  assign bus.o_wb_cyc = cyc_q;
  assign bus.o_wb_stb = stb_q;
  assign bus.o_wb_we  = we_q;
  assign bus.o_wb_sel = sel_q;
  assign bus.o_wb_adr = (AW + BW)'(adr_q) << BW;
  assign bus.o_wb_dat = dat_q;
  assign bus.o_dout   = dout_q;
  assign bus.o_ack    = ack_q;
  assign bus.o_err    = err_q;
  assign bus.o_busy   = busy_q;
endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: 32-bit and 64-bit instances, hand-computed expectations.
module tb_wb_master_bridge;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  wb_master_bridge_if #(.DW(32), .AW(30)) a ();
  wb_master_bridge_if #(.DW(64), .AW(29)) b ();

  wb_master_bridge #(.DW(32), .AW(30), .TIMEOUT(4)) dut32 (
    .i_clk(clk), .i_arst_n(rst_n), .bus(a.master));
  wb_master_bridge #(.DW(64), .AW(29), .TIMEOUT(4)) dut64 (
    .i_clk(clk), .i_arst_n(rst_n), .bus(b.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    a.i_we = 0; a.i_re = 0; a.i_sel = '0; a.i_adr = '0; a.i_din = '0;
    a.i_wb_dat = '0; a.i_wb_ack = 0; a.i_wb_err = 0;
    b.i_we = 0; b.i_re = 0; b.i_sel = '0; b.i_adr = '0; b.i_din = '0;
    b.i_wb_dat = '0; b.i_wb_ack = 0; b.i_wb_err = 0;
    #1;
    chk("rst_cyc",  a.o_wb_cyc, 0);
    chk("rst_busy", a.o_busy, 0);
    chk("rst_dout", a.o_dout, 0);
    chk("rst_adr",  a.o_wb_adr, 0);
    step();
    rst_n = 1'b1;
    step();

    // zero-wait read
    a.i_re = 1; a.i_adr = 30'h4; a.i_sel = 4'hF;
    step();
    a.i_re = 0;
    chk("rd_cyc",  a.o_wb_cyc, 1);
    chk("rd_stb",  a.o_wb_stb, 1);
    chk("rd_busy", a.o_busy, 1);
    chk("rd_we",   a.o_wb_we, 0);
    chk("rd_adr",  a.o_wb_adr, 32'h10);
    chk("rd_sel",  a.o_wb_sel, 4'hF);
    a.i_wb_ack = 1; a.i_wb_dat = 32'hDEADBEEF;
    step();
    a.i_wb_ack = 0;
    chk("rd_ack",  a.o_ack, 1);
    chk("rd_err",  a.o_err, 0);
    chk("rd_dout", a.o_dout, 32'hDEADBEEF);
    chk("rd_idle", a.o_busy, 0);
    chk("rd_cyc0", a.o_wb_cyc, 0);
    step();
    chk("rd_ack1", a.o_ack, 0);

    // write with 3 wait states; a read during busy is dropped
    a.i_we = 1; a.i_din = 32'h12345678; a.i_sel = 4'b0011; a.i_adr = 30'h7;
    step();
    a.i_we = 0;
    chk("wr_cyc", a.o_wb_cyc, 1);
    chk("wr_we",  a.o_wb_we, 1);
    chk("wr_dat", a.o_wb_dat, 32'h12345678);
    chk("wr_sel", a.o_wb_sel, 4'b0011);
    chk("wr_adr", a.o_wb_adr, 32'h1C);
    a.i_re = 1; a.i_adr = 30'h9;
    for (int i = 0; i < 3; i++) begin
      step();
      a.i_re = 0;
      chk("wr_wait_cyc", a.o_wb_cyc, 1);
      chk("wr_wait_dat", a.o_wb_dat, 32'h12345678);
      chk("wr_wait_adr", a.o_wb_adr, 32'h1C);
      chk("wr_wait_ack", a.o_ack, 0);
    end
    a.i_wb_ack = 1; a.i_wb_dat = 32'hCAFEF00D;
    step();
    a.i_wb_ack = 0;
    chk("wr_ack",  a.o_ack, 1);
    chk("wr_cyc0", a.o_wb_cyc, 0);
    chk("wr_dout", a.o_dout, 32'hDEADBEEF);
    step();
    chk("wr_drop_busy", a.o_busy, 0);
    chk("wr_drop_cyc",  a.o_wb_cyc, 0);

    // ack and err together: err wins, dout unchanged
    a.i_re = 1; a.i_adr = 30'h1;
    step();
    a.i_re = 0;
    a.i_wb_ack = 1; a.i_wb_err = 1; a.i_wb_dat = 32'h55555555;
    step();
    a.i_wb_ack = 0; a.i_wb_err = 0;
    chk("ae_err",  a.o_err, 1);
    chk("ae_ack",  a.o_ack, 0);
    chk("ae_dout", a.o_dout, 32'hDEADBEEF);
    chk("ae_cyc",  a.o_wb_cyc, 0);
    step();

    // we and re together: write issued
    a.i_we = 1; a.i_re = 1; a.i_din = 32'hA5A5A5A5; a.i_sel = 4'hF;
    step();
    a.i_we = 0; a.i_re = 0;
    chk("wr_rd_we",  a.o_wb_we, 1);
    chk("wr_rd_dat", a.o_wb_dat, 32'hA5A5A5A5);
    a.i_wb_ack = 1;
    step();
    a.i_wb_ack = 0;
    chk("wr_rd_ack", a.o_ack, 1);
    step();

    // silent slave
    a.i_re = 1; a.i_adr = 30'h2;
    step();
    a.i_re = 0;
`ifdef WB_BRIDGE_TIMEOUT_EN
    chk("tmo_stb1", a.o_wb_stb, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("tmo_stb", a.o_wb_stb, 1);
      chk("tmo_err0", a.o_err, 0);
    end
    step();
    chk("tmo_err", a.o_err, 1);
    chk("tmo_ack", a.o_ack, 0);
    chk("tmo_cyc", a.o_wb_cyc, 0);
    step();
    chk("tmo_err1", a.o_err, 0);
`else
    for (int i = 0; i < 110; i++) begin
      step();
      chk("hold_cyc", a.o_wb_cyc, 1);
      chk("hold_err", a.o_err, 0);
    end
    a.i_wb_ack = 1; a.i_wb_dat = 32'h0BADF00D;
    step();
    a.i_wb_ack = 0;
    chk("hold_ack",  a.o_ack, 1);
    chk("hold_dout", a.o_dout, 32'h0BADF00D);
    chk("hold_cyc0", a.o_wb_cyc, 0);
    step();
`endif

    // reset in the middle of a bus cycle
    a.i_we = 1; a.i_adr = 30'h3; a.i_din = 32'h11111111;
    step();
    a.i_we = 0;
    chk("mr_cyc1", a.o_wb_cyc, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_cyc",  a.o_wb_cyc, 0);
    chk("mr_stb",  a.o_wb_stb, 0);
    chk("mr_busy", a.o_busy, 0);
    chk("mr_adr",  a.o_wb_adr, 0);
    chk("mr_dout", a.o_dout, 0);
    step();
    chk("mr_ack", a.o_ack, 0);
    chk("mr_err", a.o_err, 0);
    rst_n = 1'b1;
    step();
    chk("mr_idle", a.o_wb_cyc, 0);

    // 64-bit data path
    b.i_re = 1; b.i_adr = 29'h1; b.i_sel = 8'hA5;
    step();
    b.i_re = 0;
    chk("w64_adr", b.o_wb_adr, 32'h8);
    chk("w64_sel", b.o_wb_sel, 8'hA5);
    chk("w64_cyc", b.o_wb_cyc, 1);
    b.i_wb_ack = 1; b.i_wb_dat = 64'h0123456789ABCDEF;
    step();
    b.i_wb_ack = 0;
    chk("w64_ack",  b.o_ack, 1);
    chk("w64_dout", b.o_dout, 64'h0123456789ABCDEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
